adder_amba_array: RTL

- Next-generation AXI4-Lite adder accelerator: NUM_CH independent add/sub channels behind one AXI4-Lite slave port.
- Each channel has operand, op and result registers, a LATENCY-cycle compute counter, and busy, sticky-done and carry/borrow flags.
- A global register drives 4 LEDs.
- Drop-in replacement for the single-channel adder top; software polls STATUS or waits on irq.

---
 rtl/adder_amba_array.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/adder_amba_array.sv
// NUM_CH independent add/sub channels behind one AXI4-Lite slave port.
// Each channel sits in its own adder_amba_ch instance; the top handles the bus and register decode.

module adder_amba_ch #(
   parameter int W       = 32,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           wr_a,
   input  logic           wr_b,
   input  logic           wr_op,
   input  logic [W-1:0]   wdata,
   input  logic [W/8-1:0] wstrb,
   input  logic           clr_done,
   output logic [W-1:0]   a,
   output logic [W-1:0]   b,
   output logic           op,
   output logic [W-1:0]   result,
   output logic           busy,
   output logic           done,
   output logic           carry
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] LOAD = 4'(LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;
   logic [W:0] sum;
   logic       fin;

   // Bit W is the add carry-out, or the borrow (a < b) for a subtract.
   assign sum  = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
   assign busy = (state == BUSY);
   assign fin  = (state == BUSY) && (cnt == 4'd0);

   // Operand writes are refused by the decoder while busy, so a/b/op hold
   // the values present at start for the whole computation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a      <= '0;
         b      <= '0;
         op     <= 1'b0;
         result <= '0;
         carry  <= 1'b0;
         done   <= 1'b0;
      end else begin
         for (int i = 0; i < W/8; i++) begin
            if (wr_a && wstrb[i]) a[8*i +: 8] <= wdata[8*i +: 8];
            if (wr_b && wstrb[i]) b[8*i +: 8] <= wdata[8*i +: 8];
         end
         if (wr_op && wstrb[0]) op <= wdata[0];
         case (state)
            IDLE: if (start) begin
               state <= BUSY;
               cnt   <= LOAD;
            end
            BUSY: if (cnt == 4'd0) begin
               state  <= IDLE;
               result <= sum[W-1:0];
               carry  <= sum[W];
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
         if (fin)           done <= 1'b1;
         else if (clr_done) done <= 1'b0;
      end
   end
endmodule

module adder_amba_array #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int NUM_CH             = 4,
   parameter int LATENCY            = 2
) (
   input  logic                            ACLK,
   input  logic                            ARST,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [3:0]                      o_leds,
   output logic                            o_irq
);
   localparam int         DW     = C_S_AXI_DATA_WIDTH;
   localparam int         GW     = C_S_AXI_ADDR_WIDTH - 4;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic aw_rdy, bvalid, ar_rdy, rvalid, wr_hs, ar_hs, w_err, r_err, leds_we;
   logic [1:0]    bresp, rresp;
   logic [DW-1:0] rdata, r_data_nx, status_w;
   logic [3:0]    leds;
   logic [GW-1:0] w_grp, r_grp;
   logic [1:0]    w_sel, r_sel;

   logic [NUM_CH-1:0]         start, wr_a, wr_b, wr_op, clr_done, busy, done, carry, op;
   logic [NUM_CH-1:0][DW-1:0] a, b, result;

   logic unused;
   assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                     S_AXI_ARADDR[1:0], S_AXI_WDATA, S_AXI_WSTRB};

   // Word address split: group 0 = global registers, group c+1 = channel c.
   assign w_grp = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign w_sel = S_AXI_AWADDR[3:2];
   assign r_grp = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4];
   assign r_sel = S_AXI_ARADDR[3:2];

   assign wr_hs = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
   assign ar_hs = ar_rdy & S_AXI_ARVALID;

   always_comb begin
      w_err    = 1'b0;
      leds_we  = 1'b0;
      start    = '0;
      wr_a     = '0;
      wr_b     = '0;
      wr_op    = '0;
      clr_done = '0;
      if (wr_hs) begin
         if (w_grp == '0) begin
            case (w_sel)
               2'd0:    if (S_AXI_WSTRB[0]) start = S_AXI_WDATA[NUM_CH-1:0];
               2'd1:    if (S_AXI_WSTRB[2]) clr_done = S_AXI_WDATA[16 +: NUM_CH];
               2'd2:    leds_we = S_AXI_WSTRB[0];
               default: w_err = 1'b1;
            endcase
         end else if (int'(w_grp) > NUM_CH) begin
            w_err = 1'b1;
         end else begin
            for (int c = 0; c < NUM_CH; c++) begin
               if (w_grp == GW'(c + 1)) begin
                  if (w_sel == 2'd3 || busy[c]) w_err = 1'b1;
                  else begin
                     wr_a[c]  = (w_sel == 2'd0);
                     wr_b[c]  = (w_sel == 2'd1);
                     wr_op[c] = (w_sel == 2'd2);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      status_w                = '0;
      status_w[NUM_CH-1:0]    = busy;
      status_w[16 +: NUM_CH]  = done;
   end

   always_comb begin
      r_data_nx = '0;
      r_err     = 1'b0;
      if (r_grp == '0) begin
         case (r_sel)
            2'd1:    r_data_nx = status_w;
            2'd2:    r_data_nx = DW'(leds);
            2'd3:    r_data_nx = DW'(carry);
            default: r_data_nx = '0;
         endcase
      end else if (int'(r_grp) > NUM_CH) begin
         r_err = 1'b1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (r_grp == GW'(c + 1)) begin
               case (r_sel)
                  2'd0:    r_data_nx = a[c];
                  2'd1:    r_data_nx = b[c];
                  2'd2:    r_data_nx = DW'(op[c]);
                  default: r_data_nx = result[c];
               endcase
            end
         end
      end
   end

   // AW and W are only taken together, and never while a B response is pending.
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         aw_rdy <= 1'b0;
         bvalid <= 1'b0;
         bresp  <= OKAY;
         leds   <= '0;
      end else begin
         aw_rdy <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid && !aw_rdy;
         if (wr_hs) begin
            bvalid <= 1'b1;
            bresp  <= w_err ? SLVERR : OKAY;
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
         if (leds_we) leds <= S_AXI_WDATA[3:0];
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARST) begin
         ar_rdy <= 1'b0;
         rvalid <= 1'b0;
         rresp  <= OKAY;
         rdata  <= '0;
      end else if (ar_hs) begin
         ar_rdy <= 1'b0;
         rvalid <= 1'b1;
         rdata  <= r_data_nx;
         rresp  <= r_err ? SLVERR : OKAY;
      end else if (rvalid && S_AXI_RREADY) begin
         ar_rdy <= 1'b1;
         rvalid <= 1'b0;
      end else if (!rvalid) begin
         ar_rdy <= 1'b1;
      end
   end

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         adder_amba_ch #(.W(DW), .LATENCY(LATENCY)) u_ch (
            .clk(ACLK), .rst(ARST), .start(start[g]),
            .wr_a(wr_a[g]), .wr_b(wr_b[g]), .wr_op(wr_op[g]),
            .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .clr_done(clr_done[g]),
            .a(a[g]), .b(b[g]), .op(op[g]), .result(result[g]),
            .busy(busy[g]), .done(done[g]), .carry(carry[g])
         );
      end
   endgenerate

   assign S_AXI_AWREADY = aw_rdy;
   assign S_AXI_WREADY  = aw_rdy;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = ar_rdy;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = rresp;
   assign o_leds        = leds;
   assign o_irq         = |done;
endmodule
